// File: rtl/rv32i_sequencer.sv
// Multi-cycle RV32I fetch/decode/branch sequencer.
// Fetches one instruction at a time, decodes it into the datapath control
// word and immediate, and owns the PC plus the branch/jump resolution.
module rv32i_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [22:0] cword,
  output logic [31:0] pc,
  output logic [31:0] imm,
  input  logic [31:0] r_for_pc,
  input  logic [3:0]  funit_ZCNVFlags,
  output logic        retire,
  output logic [31:0] instret,
  output logic        halted,
  output logic [1:0]  fault_cause
);

  localparam int unsigned   WW        = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(IMEM_TIMEOUT - 1);
  localparam logic [22:0]   BUBBLE    = 23'h000001;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_HALT, S_FAULT
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     imm_q, imm_d;
  logic [31:0]     instret_q, instret_d;
  logic [22:0]     cword_q, cword_d;
  logic [1:0]      fault_q, fault_d;
  logic [WW-1:0]   wait_q, wait_d;
  // arm_q keeps imem_req low for the first cycle after reset release
  logic            arm_q, arm_d;

  // Instruction fields and immediate formats of the held instruction
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr_q[6:0];
  assign f3     = instr_q[14:12];
  assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b  = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u  = {instr_q[31:12], 12'b0};
  assign imm_j  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  logic [3:0]  dec_type;
  logic [2:0]  dec_f3;
  logic        dec_f7;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;
  logic        dec_legal;

  // Decode: unused register fields are zeroed; branches become a SUB compare
  always_comb begin
    dec_type  = 4'd1;
    dec_f3    = f3;
    dec_f7    = 1'b0;
    dec_rd    = instr_q[11:7];
    dec_rs1   = instr_q[19:15];
    dec_rs2   = 5'd0;
    dec_imm   = 32'd0;
    dec_legal = 1'b1;
    case (opcode)
      OP_LOAD:   begin dec_type = 4'd0; dec_imm = imm_i; end
      OP_IMM:    begin
        dec_type = 4'd1; dec_imm = imm_i;
        dec_f7   = (f3 == 3'b101) ? instr_q[30] : 1'b0;
      end
      OP_STORE:  begin dec_type = 4'd2; dec_imm = imm_s; dec_rd = 5'd0; dec_rs2 = instr_q[24:20]; end
      OP_REG:    begin dec_type = 4'd3; dec_f7 = instr_q[30]; dec_rs2 = instr_q[24:20]; end
      OP_LUI:    begin dec_type = 4'd4; dec_imm = imm_u; dec_rs1 = 5'd0; dec_f3 = 3'b000; end
      OP_AUIPC:  begin dec_type = 4'd5; dec_imm = imm_u; dec_rs1 = 5'd0; dec_f3 = 3'b000; end
      OP_BRANCH: begin
        dec_type = 4'd3; dec_f3 = 3'b000; dec_f7 = 1'b1;
        dec_rd   = 5'd0; dec_rs2 = instr_q[24:20]; dec_imm = imm_b;
      end
      OP_JALR:   begin dec_type = 4'd7; dec_imm = imm_i; end
      OP_JAL:    begin dec_type = 4'd8; dec_imm = imm_j; dec_rs1 = 5'd0; dec_f3 = 3'b000; end
      default:   dec_legal = 1'b0;
    endcase
  end

  logic        br_taken, br_bad, exec_ok;
  logic [31:0] npc;
  logic        fl_z, fl_c, fl_n, fl_v;

  assign {fl_z, fl_c, fl_n, fl_v} = funit_ZCNVFlags;

  // Branch condition and next-pc selection, evaluated during EXEC
  always_comb begin
    case (f3)
      3'b000:  br_taken = fl_z;
      3'b001:  br_taken = ~fl_z;
      3'b100:  br_taken = fl_n ^ fl_v;
      3'b101:  br_taken = ~(fl_n ^ fl_v);
      3'b110:  br_taken = ~fl_c;
      3'b111:  br_taken = fl_c;
      default: br_taken = 1'b0;
    endcase
    br_bad = (opcode == OP_BRANCH) && (f3 == 3'b010 || f3 == 3'b011);
    npc    = pc_q + 32'd4;
    if ((opcode == OP_BRANCH && br_taken) || opcode == OP_JAL)
      npc = pc_q + imm_q;
    else if (opcode == OP_JALR)
      npc = (r_for_pc + imm_q) & ~32'd1;
    exec_ok = ~br_bad & ~npc[1];
  end

  // State register and all sequencer flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      cword_q   <= BUBBLE;
      imm_q     <= '0;
      instret_q <= '0;
      fault_q   <= '0;
      wait_q    <= '0;
      arm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      cword_q   <= cword_d;
      imm_q     <= imm_d;
      instret_q <= instret_d;
      fault_q   <= fault_d;
      wait_q    <= wait_d;
      arm_q     <= arm_d;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    cword_d   = cword_q;
    imm_d     = imm_q;
    instret_d = instret_q;
    fault_d   = fault_q;
    wait_d    = wait_q;
    arm_d     = 1'b1;
    case (state_q)
      S_FETCH: if (arm_q) begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          wait_d  = '0;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          fault_d = 2'b10;
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DECODE: begin
        if (opcode == OP_FENCE) begin
          pc_d      = pc_q + 32'd4;
          instret_d = instret_q + 32'd1;
          state_d   = S_FETCH;
        end else if (opcode == OP_SYSTEM) begin
          state_d = S_HALT;
        end else if (!dec_legal) begin
          fault_d = 2'b01;
          state_d = S_FAULT;
        end else begin
          cword_d = {dec_rs2, dec_rs1, dec_rd, dec_f7, dec_f3, dec_type};
          imm_d   = dec_imm;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (br_bad) begin
          fault_d = 2'b01;
          state_d = S_FAULT;
        end else if (npc[1]) begin
          fault_d = 2'b11;
          state_d = S_FAULT;
        end else begin
          pc_d      = npc;
          instret_d = instret_q + 32'd1;
          state_d   = S_FETCH;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Outputs: EXEC drives the decoded word, every other state drives BUBBLE;
  // rst masks strobes so an interrupted EXEC leaves no write behind
  always_comb begin
    imem_req = 1'b0;
    cword    = BUBBLE;
    retire   = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_FETCH:  imem_req = arm_q & ~rst;
      S_DECODE: retire   = (opcode == OP_FENCE) & ~rst;
      S_EXEC:   if (!rst) begin
        cword  = cword_q;
        retire = exec_ok;
      end
      S_HALT, S_FAULT: halted = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign imm         = imm_q;
  assign instret     = instret_q;
  assign fault_cause = fault_q;

endmodule

// File: tb/tb_rv32i_sequencer.sv
// Scoreboard bench for rv32i_sequencer: randomized instruction stream with a
// field-level reference model; a monitor checks each retire and each halt.
module tb_rv32i_sequencer;

  localparam logic [31:0] RPC    = 32'h0000_0000;
  localparam logic [22:0] BUBBLE = 23'h000001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_valid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [22:0] cword;
  logic [31:0] pc, imm, r_for_pc = '0, instret;
  logic [3:0]  flags = '0;
  logic        retire, halted;
  logic [1:0]  fault_cause;

  always #5 clk = ~clk;

  rv32i_sequencer #(.RESET_PC(RPC), .IMEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .cword(cword), .pc(pc), .imm(imm),
    .r_for_pc(r_for_pc), .funit_ZCNVFlags(flags),
    .retire(retire), .instret(instret), .halted(halted), .fault_cause(fault_cause)
  );

  typedef struct {
    logic        is_halt;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic [22:0] cw;
    logic [31:0] imm;
    logic        chk_imm;
    logic [1:0]  cause;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_pc, m_cnt;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [22:0] cw(input logic [3:0] t, input logic [2:0] f3, input logic f7,
                                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {rs2, rs1, rd, f7, f3, t};
  endfunction

  function automatic bit known_op(input logic [6:0] op);
    return op inside {7'h03, 7'h13, 7'h23, 7'h33, 7'h37, 7'h17, 7'h63, 7'h67, 7'h6f, 7'h0f, 7'h73};
  endfunction

  // Monitor: pop and compare whenever the DUT retires or newly halts
  exp_t e_m;
  logic prev_h = 1'b0;
  always @(negedge clk) begin
    if (!rst && (retire || (halted && !prev_h))) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_event: retire=%b halted=%b pc=%h, no event expected", retire, halted, pc);
      end else begin
        e_m = sbq.pop_front();
        chk("event_is_halt", 32'(halted), 32'(e_m.is_halt));
        chk("event_pc", pc, e_m.pc);
        chk("event_instret", instret, e_m.cnt);
        if (e_m.is_halt) begin
          chk("halt_cause", 32'(fault_cause), 32'(e_m.cause));
          chk("halt_cword", 32'(cword), 32'(BUBBLE));
          chk("halt_imem_req", 32'(imem_req), 32'd0);
        end else begin
          chk("exec_cword", 32'(cword), 32'(e_m.cw));
          if (e_m.chk_imm) chk("exec_imm", imm, e_m.imm);
        end
      end
    end
    prev_h <= halted;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 with imem_req seen high
  task automatic wait_req(output bit ok);
    int k = 0;
    while (k < 60 && !imem_req) begin @(posedge clk); #1; k++; end
    ok = imem_req;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL fetch_req_timeout: imem_req=0 required 1");
    end
  endtask

  task automatic fetch(input logic [31:0] ins, input logic [31:0] r, input logic [3:0] fl,
                       input int dly, output bit ok);
    wait_req(ok);
    if (!ok) return;
    chk("imem_addr", imem_addr, m_pc);
    repeat (dly) begin @(posedge clk); #1; end
    imem_rdata = ins; imem_valid = 1'b1; r_for_pc = r; flags = fl;
    @(posedge clk); #1;
    imem_valid = 1'b0; imem_rdata = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_pc = RPC; m_cnt = 0;
    chk("rst_pc", pc, RPC);
    chk("rst_instret", instret, 32'd0);
    chk("rst_cword", 32'(cword), 32'(BUBBLE));
    chk("rst_imm", imm, 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_flags", {29'd0, retire, fault_cause}, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    sbq.delete();
  endtask

  function automatic exp_t mk_ret(input logic [22:0] c, input logic [31:0] i, input logic ci);
    exp_t e;
    e.is_halt = 1'b0; e.pc = m_pc; e.cnt = m_cnt; e.cw = c; e.imm = i; e.chk_imm = ci; e.cause = 2'b00;
    return e;
  endfunction

  function automatic exp_t mk_halt(input logic [1:0] cause);
    exp_t e;
    e.is_halt = 1'b1; e.pc = m_pc; e.cnt = m_cnt; e.cw = BUBBLE; e.imm = '0; e.chk_imm = 1'b0; e.cause = cause;
    return e;
  endfunction

  // Issue one retiring instruction and advance the model
  task automatic run_ret(input logic [31:0] ins, input logic [31:0] r, input logic [3:0] fl,
                         input exp_t e, input logic [31:0] npc, input int dly);
    bit ok;
    sbq.push_back(e);
    fetch(ins, r, fl, dly, ok);
    m_pc = npc; m_cnt = m_cnt + 1;
  endtask

  // Random non-terminal instruction, expectations built from generated fields
  task automatic make_rand(output logic [31:0] ins, output logic [31:0] r, output logic [3:0] fl,
                           output exp_t e, output logic [31:0] npc);
    int c, o, k;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [11:0] i12;
    logic [19:0] u20;
    logic [12:0] b;
    logic [20:0] j;
    logic b30, tk;
    c = $urandom_range(0, 9);
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    f3 = 3'($urandom); i12 = 12'($urandom); u20 = 20'($urandom); b30 = 1'($urandom);
    r = $urandom; fl = 4'($urandom);
    npc = m_pc + 32'd4;
    e = mk_ret(BUBBLE, 32'd0, 1'b1);
    case (c)
      0: begin
        k = $urandom_range(0, 4); f3 = 3'((k < 3) ? k : k + 1);
        ins = {i12, rs1, f3, rd, 7'h03};
        e.cw = cw(4'd0, f3, 1'b0, rd, rs1, 5'd0); e.imm = 32'($signed(i12));
      end
      1: begin
        if (f3 == 3'b001) i12 = {7'b0, i12[4:0]};
        if (f3 == 3'b101) i12 = {1'b0, b30, 5'b0, i12[4:0]};
        ins = {i12, rs1, f3, rd, 7'h13};
        e.cw = cw(4'd1, f3, (f3 == 3'b101) ? b30 : 1'b0, rd, rs1, 5'd0); e.imm = 32'($signed(i12));
      end
      2: begin
        f3 = 3'($urandom_range(0, 2));
        ins = {i12[11:5], rs2, rs1, f3, i12[4:0], 7'h23};
        e.cw = cw(4'd2, f3, 1'b0, 5'd0, rs1, rs2); e.imm = 32'($signed(i12));
      end
      3: begin
        ins = {1'b0, b30, 5'b0, rs2, rs1, f3, rd, 7'h33};
        e.cw = cw(4'd3, f3, b30, rd, rs1, rs2); e.imm = 32'd0;
      end
      4, 5: begin
        ins = {u20, rd, (c == 4) ? 7'h37 : 7'h17};
        e.cw = cw((c == 4) ? 4'd4 : 4'd5, 3'b000, 1'b0, rd, 5'd0, 5'd0); e.imm = {u20, 12'b0};
      end
      6: begin
        k = $urandom_range(0, 5); f3 = 3'((k < 2) ? k : k + 2);
        o = int'($urandom_range(0, 2047)) * 4 - 4096; b = o[12:0];
        ins = {b[12], b[10:5], rs2, rs1, f3, b[4:1], b[11], 7'h63};
        e.cw = cw(4'd3, 3'b000, 1'b1, 5'd0, rs1, rs2); e.imm = 32'(o);
        case (f3)
          3'b000: tk = fl[3];
          3'b001: tk = !fl[3];
          3'b100: tk = fl[1] ^ fl[0];
          3'b101: tk = !(fl[1] ^ fl[0]);
          3'b110: tk = !fl[2];
          default: tk = fl[2];
        endcase
        if (tk) npc = m_pc + 32'(o);
      end
      7: begin
        i12 = i12 & 12'hffc; r = r & ~32'h2;
        ins = {i12, rs1, 3'b000, rd, 7'h67};
        e.cw = cw(4'd7, 3'b000, 1'b0, rd, rs1, 5'd0); e.imm = 32'($signed(i12));
        npc = (r + 32'($signed(i12))) & ~32'h1;
      end
      8: begin
        o = int'($urandom_range(0, 262143)) * 4 - 1048576; j = o[20:0];
        ins = {j[20], j[10:1], j[11], j[19:12], rd, 7'h6f};
        e.cw = cw(4'd8, 3'b000, 1'b0, rd, 5'd0, 5'd0); e.imm = 32'(o);
        npc = m_pc + 32'(o);
      end
      default: begin
        ins = 32'h0ff0000f; e.cw = BUBBLE; e.chk_imm = 1'b0;
      end
    endcase
  endtask

  // Random terminating scenario: halt, illegal, timeout or misaligned target
  task automatic run_term();
    int c, o;
    bit ok;
    logic [31:0] ins, r;
    logic [11:0] i12;
    logic [6:0] op;
    logic [20:0] j;
    c = $urandom_range(0, 5);
    r = $urandom; i12 = 12'($urandom) & 12'hffc;
    case (c)
      0: begin sbq.push_back(mk_halt(2'b00));
        fetch(($urandom_range(0, 1) == 1) ? 32'h00100073 : 32'h00000073, r, 4'($urandom), 0, ok); end
      1: begin
        do op = 7'($urandom); while (known_op(op));
        ins = $urandom; ins[6:0] = op;
        sbq.push_back(mk_halt(2'b01)); fetch(ins, r, 4'($urandom), 0, ok);
      end
      2: begin
        sbq.push_back(mk_halt(2'b10)); wait_req(ok);
        repeat (20) @(posedge clk); #1;
      end
      3: begin sbq.push_back(mk_halt(2'b11));
        fetch({i12, 5'($urandom), 3'b000, 5'($urandom), 7'h67}, r | 32'h2, 4'($urandom), 0, ok); end
      4: begin sbq.push_back(mk_halt(2'b01));
        fetch({7'h00, 5'd2, 5'd1, 3'($urandom_range(2, 3)), 5'h08, 7'h63}, r, 4'($urandom), 0, ok); end
      default: begin
        o = int'($urandom_range(0, 262143)) * 4 - 1048576 + 2; j = o[20:0];
        sbq.push_back(mk_halt(2'b11));
        fetch({j[20], j[10:1], j[11], j[19:12], 5'd1, 7'h6f}, r, 4'($urandom), 0, ok);
      end
    endcase
    repeat (4) @(posedge clk); #1;
    chk("term_halted", 32'(halted), 32'd1);
  endtask

  initial begin
    logic [31:0] ins, r, npc;
    logic [3:0] fl;
    exp_t e;
    bit ok;

    // ADDI x1,x0,5 from reset: retire in the third cycle of the fetch
    do_reset();
    sbq.push_back(mk_ret(cw(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0), 32'd5, 1'b1));
    fetch(32'h00500093, 32'd0, 4'd0, 0, ok);
    @(posedge clk); #1;
    chk("addi_retire_cycle", 32'(retire), 32'd1);
    chk("addi_cword", 32'(cword), 32'({5'd0, 5'd0, 5'd1, 1'b0, 3'b000, 4'd1}));
    @(posedge clk); #1;
    chk("addi_pc", pc, 32'd4);
    chk("addi_instret", instret, 32'd1);
    m_pc = 4; m_cnt = 1;
    run_ret(32'h00500093, 32'd0, 4'd0, mk_ret(cw(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0), 32'd5, 1'b1), 32'd8, 0);
    // BEQ x1,x2,+16 taken at 8 then not taken at 24
    run_ret(32'h00208863, 32'd0, 4'b1000, mk_ret(cw(4'd3, 3'b000, 1'b1, 5'd0, 5'd1, 5'd2), 32'd16, 1'b1), 32'd24, 0);
    run_ret(32'h00208863, 32'd0, 4'b0000, mk_ret(cw(4'd3, 3'b000, 1'b1, 5'd0, 5'd1, 5'd2), 32'd16, 1'b1), 32'd28, 0);
    // JALR x1,8(x5): aligned, then misaligned target
    run_ret(32'h008280E7, 32'h101, 4'd0, mk_ret(cw(4'd7, 3'b000, 1'b0, 5'd1, 5'd5, 5'd0), 32'd8, 1'b1), 32'h108, 0);
    sbq.push_back(mk_halt(2'b11));
    fetch(32'h008280E7, 32'h102, 4'd0, 0, ok);
    repeat (4) @(posedge clk); #1;
    chk("jalr_mis_halted", 32'(halted), 32'd1);
    chk("jalr_mis_pc", pc, 32'h108);

    // Fetch timeout, then a late strobe must be ignored
    do_reset();
    sbq.push_back(mk_halt(2'b10));
    wait_req(ok);
    repeat (20) @(posedge clk); #1;
    imem_rdata = 32'h00500093; imem_valid = 1'b1;
    @(posedge clk); #1 imem_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("timeout_halted", 32'(halted), 32'd1);
    chk("timeout_cause", 32'(fault_cause), 32'd2);
    chk("timeout_instret", instret, 32'd0);

    // Illegal opcode, then ECALL after one retirement
    do_reset();
    sbq.push_back(mk_halt(2'b01));
    fetch(32'hFFFFFFFF, 32'd0, 4'd0, 0, ok);
    repeat (4) @(posedge clk); #1;
    do_reset();
    run_ret(32'h00500093, 32'd0, 4'd0, mk_ret(cw(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0), 32'd5, 1'b1), 32'd4, 2);
    sbq.push_back(mk_halt(2'b00));
    fetch(32'h00000073, 32'd0, 4'd0, 0, ok);
    repeat (4) @(posedge clk); #1;
    chk("ecall_instret", instret, 32'd1);
    chk("ecall_cause", 32'(fault_cause), 32'd0);

    // Reset during EXEC of SW, then during a fetch wait
    do_reset();
    fetch(32'h0020A023, 32'd0, 4'd0, 0, ok);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_exec_cword", 32'(cword), 32'(BUBBLE));
    chk("rst_exec_retire", 32'(retire), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_exec_pc", pc, RPC);
    chk("rst_exec_instret", instret, 32'd0);
    chk("rst_exec_cword_after", 32'(cword), 32'(BUBBLE));
    m_pc = RPC; m_cnt = 0;
    wait_req(ok);
    repeat (3) @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_wait_req_low", 32'(imem_req), 32'd0);
    imem_rdata = 32'h00700193; imem_valid = 1'b1;
    @(posedge clk); #1 imem_valid = 1'b0;
    run_ret(32'h00500093, 32'd0, 4'd0, mk_ret(cw(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0), 32'd5, 1'b1), 32'd4, 0);
    repeat (3) @(posedge clk); #1;
    chk("restart_pc", pc, 32'd4);

    // Random segments, each closed by a terminating scenario
    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int i = 0; i < 20; i++) begin
        make_rand(ins, r, fl, e, npc);
        run_ret(ins, r, fl, e, npc, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : 0);
      end
      run_term();
    end

    repeat (5) @(posedge clk); #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32i_sequencer.md
Name: rv32i_sequencer

Overview:
Multi-cycle control unit that fetches RV32I instructions from instruction memory and decodes each one into the datapath's 23-bit control word and 32-bit immediate. It also owns the PC and resolves branches and jumps using the datapath's rs1 value and ZCNV flags. It sits between the instruction memory port and the datapath, one instruction in flight at a time.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_TIMEOUT, 16, maximum FETCH cycles without imem_valid before a fault

Ports:
clk  input  1  system clock
rst  input  1  reset
imem_req  output  1  fetch request, held high until imem_valid
imem_addr  output  32  byte address of the fetch; always equals pc
imem_rdata  input  32  instruction word, valid when imem_valid=1
imem_valid  input  1  instruction-return strobe, ignored while imem_req=0
cword  output  23  datapath control word
pc  output  32  current instruction address
imm  output  32  decoded immediate
r_for_pc  input  32  datapath rs1 read value
funit_ZCNVFlags  input  4  [3]=Z, [2]=C (1 = no borrow, A>=B unsigned), [1]=N, [0]=V
retire  output  1  one-cycle pulse when an instruction completes
instret  output  32  retired-instruction counter, wraps at 2^32
halted  output  1  sticky; set on ECALL/EBREAK or on a fault
fault_cause  output  2  00 none, 01 illegal opcode, 10 imem timeout, 11 misaligned target

Behaviour:
- Clocking and reset: one clock `clk`; `rst` is synchronous and active-high.
- Reset values:
  - state = FETCH, pc = RESET_PC
  - cword = BUBBLE, imm = 0, imem_req = 0
  - retire = 0, instret = 0, halted = 0, fault_cause = 00
  - A pending fetch or execute is abandoned, with no write side effects.
- cword packing: [3:0] instType, [6:4] funct3, [7] fun7, [12:8] rd, [17:13] rs1, [22:18] rs2.
- instType codes: load 0, imm 1, store 2, reg 3, lui 4, auipc 5, branch 6, jalr 7, jal 8.
- fun7 rule: fun7 = instr[30] for reg ops, and for imm ops with funct3=101; 0 otherwise.
- BUBBLE = 23'h000001 (ADDI x0,x0,0). It is driven in every state except EXEC, so the datapath's regfile write always targets x0.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_valid, capture imem_rdata and go to DECODE.
  - A wait counter increments each FETCH cycle. Reaching IMEM_TIMEOUT without imem_valid → FAULT with cause 10.
- DECODE (1 cycle):
  - Register the cword fields and imm.
  - Immediate formats: I, S, B, J sign-extended; U = {instr[31:12],12'b0}.
  - Supported opcodes: 0000011, 0010011, 0100011, 0110011, 0110111, 0010111, 1100011, 1100111, 1101111.
  - 0001111 (FENCE) is a NOP: no EXEC, retire, pc+4.
  - 1110011 (ECALL/EBREAK) → HALT; it is not retired.
  - Any other opcode → FAULT with cause 01.
- EXEC (exactly 1 cycle):
  - Drive the decoded cword and imm; the datapath commits regfile and datamem writes at this cycle's closing edge.
  - Branches are driven as a compare cword instead: instType=3, funct3=000, fun7=1 (SUB), rd=0, with rs1 and rs2 from the instruction.
  - Branch condition is sampled from funit_ZCNVFlags at the closing edge:
    - BEQ Z, BNE !Z
    - BLT N^V, BGE !(N^V)
    - BLTU !C, BGEU C
    - funct3 010/011 → FAULT with cause 01
  - Next-pc selection:
    - taken branch → pc+imm
    - jal → pc+imm
    - jalr → (r_for_pc+imm) & ~1
    - otherwise → pc+4
  - All pc arithmetic is mod 2^32.
  - If the next pc has bit 1 set → FAULT with cause 11; pc is not updated and the instruction is not retired.
  - Otherwise: retire=1 for this cycle, instret+1, pc updated, go to FETCH.
- Throughput: 3 cycles per instruction when imem_valid returns in the first FETCH cycle.
- HALT/FAULT:
  - Terminal; only rst leaves them.
  - cword=BUBBLE, imem_req=0, halted=1.
  - fault_cause holds the first cause recorded; it stays 00 for HALT.
- imem_valid arriving outside FETCH is ignored.

Test Plan:
- Reset, RESET_PC=0, imem returns 0x00500093 (ADDI x1,x0,5) with zero wait → imem_req rises the cycle after reset release. EXEC cword = {5'd0,5'd0,5'd1,1'b0,3'b000,4'd1}, imm=5. retire pulses 3 cycles after the fetch starts; pc=4, instret=1.
- BEQ x1,x2,+16 (0x00208863) at pc=8, flags Z=1 during EXEC → EXEC cword instType=3, fun7=1, rd=0; pc becomes 24. Repeat with Z=0 → pc becomes 12.
- JALR x1,8(x5) with r_for_pc=0x101 → pc becomes 0x108 (bit 0 cleared). With r_for_pc=0x102 instead → halted=1, fault_cause=11, pc unchanged, no retire.
- imem_valid held low with IMEM_TIMEOUT=16 → after 16 FETCH cycles halted=1, fault_cause=10, imem_req=0, cword=23'h000001.
- Instruction 0xFFFFFFFF → fault_cause=01, halted=1, no EXEC cycle. ECALL (0x00000073) → halted=1, fault_cause=00, instret unchanged.
- Assert rst during an EXEC of SW, then during a FETCH wait → next cycle pc=RESET_PC, instret=0, cword=BUBBLE; a late imem_valid is ignored, and fetch restarts at RESET_PC.
